// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan sequencer.
package display_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    ON
  } scan_state_e;

  localparam logic [3:0] DIG_OFF = 4'b1111;

  // Next enabled digit after cur, searching upward modulo 4; returns cur when no other digit is enabled.
  function automatic logic [1:0] next_enabled(input logic [3:0] mask, input logic [1:0] cur);
    logic [1:0] idx;
    next_enabled = cur;
    for (int i = 3; i >= 1; i--) begin
      idx = cur + 2'(i);
      if (mask[idx]) next_enabled = idx;
    end
  endfunction

endpackage

// File: rtl/display_scan_ctrl_step_sync.sv
// Two-flop synchroniser for an asynchronous panel button with a one-cycle rising-edge pulse.
module step_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], btn};
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of a 4-digit display with blanking gaps, skip mask, blinking and manual stepping.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int DWELL_CYC    = 12500,
  parameter int BLANK_CYC    = 250,
  parameter int BLINK_FRAMES = 250
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [3:0] DigitMask,
  input  logic [3:0] BlinkMask,
  input  logic       Manual,
  input  logic       Step,
  output logic [1:0] Sel,
  output logic [3:0] Dig_n,
  output logic       Blank,
  output logic       FrameTick
);

  localparam int TMAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(BLINK_FRAMES + 1);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYC - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  scan_state_e   state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [FW-1:0] frame_cnt, frame_nx;
  logic [1:0]    sel_nx;
  logic [3:0]    dig_nx;
  logic          phase, phase_nx;
  logic          advance, tick_nx, step_rise;

  step_sync u_step_sync (
    .clk  (Clk),
    .rst_n(Rst_n),
    .btn  (Step),
    .rise (step_rise)
  );

  always_comb begin
    state_nx = state;
    sel_nx   = Sel;
    timer_nx = timer;
    advance  = 1'b0;
    if (DigitMask == 4'b0000) begin
      state_nx = IDLE;
      timer_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          sel_nx   = next_enabled(DigitMask, 2'd3);
          state_nx = GAP;
          timer_nx = '0;
        end
        GAP: begin
          if (timer == BLANK_LAST) begin
            state_nx = ON;
            timer_nx = '0;
          end else begin
            timer_nx = timer + TW'(1);
          end
        end
        ON: begin
          // A digit dropped from the mask ends its slot at once; manual mode holds the timer at zero.
          if (!DigitMask[Sel]) begin
            advance = 1'b1;
          end else if (Manual) begin
            timer_nx = '0;
            advance  = step_rise;
          end else if (timer == DWELL_LAST) begin
            advance = 1'b1;
          end else begin
            timer_nx = timer + TW'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    if (advance) begin
      sel_nx   = next_enabled(DigitMask, Sel);
      state_nx = GAP;
      timer_nx = '0;
    end

    tick_nx  = advance && (sel_nx <= Sel);
    frame_nx = frame_cnt;
    phase_nx = phase;
    if (tick_nx) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_nx = '0;
        phase_nx = ~phase;
      end else begin
        frame_nx = frame_cnt + FW'(1);
      end
    end

    dig_nx = DIG_OFF;
    if (state_nx == ON && !(BlinkMask[sel_nx] && phase_nx)) dig_nx[sel_nx] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= IDLE;
      Sel       <= '0;
      timer     <= '0;
      frame_cnt <= '0;
      phase     <= 1'b0;
      Dig_n     <= DIG_OFF;
      Blank     <= 1'b1;
      FrameTick <= 1'b0;
    end else begin
      state     <= state_nx;
      Sel       <= sel_nx;
      timer     <= timer_nx;
      frame_cnt <= frame_nx;
      phase     <= phase_nx;
      Dig_n     <= dig_nx;
      Blank     <= (state_nx != ON);
      FrameTick <= tick_nx;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: cycle-level behavioural model plus directed and random stimulus.
module tb_display_scan_ctrl;

  localparam int DWELL  = 4;
  localparam int BLANK  = 2;
  localparam int BLINKF = 2;
  localparam int M_IDLE = 0;
  localparam int M_GAP  = 1;
  localparam int M_ON   = 2;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Manual = 1'b0;
  logic       Step = 1'b0;
  logic [3:0] DigitMask = 4'b0000;
  logic [3:0] BlinkMask = 4'b0000;
  logic [1:0] Sel;
  logic [3:0] Dig_n;
  logic       Blank;
  logic       FrameTick;

  int testsRun = 0;
  int testsFailed = 0;

  int mState = M_IDLE;
  int mLeft = 0;
  int mSel = 0;
  int mFrames = 0;
  int mPhase = 0;
  int mTick = 0;
  int stepHist[3] = '{0, 0, 0};

  always #5 Clk = ~Clk;

  display_scan_ctrl #(
    .DWELL_CYC   (DWELL),
    .BLANK_CYC   (BLANK),
    .BLINK_FRAMES(BLINKF)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .DigitMask(DigitMask),
    .BlinkMask(BlinkMask),
    .Manual   (Manual),
    .Step     (Step),
    .Sel      (Sel),
    .Dig_n    (Dig_n),
    .Blank    (Blank),
    .FrameTick(FrameTick)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Enabled digits in ascending order; the first one above cur, else wrap to the lowest.
  function automatic int nextEnabled(input logic [3:0] mask, input int cur);
    int list[$];
    for (int i = 0; i < 4; i++) if (mask[i]) list.push_back(i);
    foreach (list[k]) if (list[k] > cur) return list[k];
    return list[0];
  endfunction

  function automatic int expDig();
    if (mState == M_ON && !(BlinkMask[mSel] && mPhase == 1)) return 15 & ~(1 << mSel);
    return 15;
  endfunction

  task automatic modelStep();
    bit pulse;
    bit endSlot;
    int ns;
    mTick = 0;
    if (!Rst_n) begin
      mState = M_IDLE; mSel = 0; mLeft = 0; mFrames = 0; mPhase = 0;
      stepHist = '{0, 0, 0};
      return;
    end
    pulse = (stepHist[1] == 1) && (stepHist[2] == 0);
    stepHist[2] = stepHist[1];
    stepHist[1] = stepHist[0];
    stepHist[0] = int'(Step);
    if (DigitMask == 4'b0000) begin
      mState = M_IDLE;
      return;
    end
    case (mState)
      M_IDLE: begin
        mSel = nextEnabled(DigitMask, 3);
        mState = M_GAP;
        mLeft = BLANK;
      end
      M_GAP: begin
        mLeft--;
        if (mLeft == 0) begin
          mState = M_ON;
          mLeft = DWELL;
        end
      end
      default: begin
        endSlot = 0;
        if (!DigitMask[mSel]) endSlot = 1;
        else if (Manual) begin
          mLeft = DWELL;
          if (pulse) endSlot = 1;
        end else begin
          mLeft--;
          if (mLeft == 0) endSlot = 1;
        end
        if (endSlot) begin
          ns = nextEnabled(DigitMask, mSel);
          if (ns <= mSel) begin
            mTick = 1;
            mFrames++;
            if (mFrames == BLINKF) begin
              mFrames = 0;
              mPhase ^= 1;
            end
          end
          mSel = ns;
          mState = M_GAP;
          mLeft = BLANK;
        end
      end
    endcase
  endtask

  // Model advances on every active edge; outputs are compared shortly after.
  always @(posedge Clk) begin
    modelStep();
    #1;
    checkOutput("sel", int'(Sel), mSel);
    checkOutput("dig_n", int'(Dig_n), expDig());
    checkOutput("blank", int'(Blank), int'(mState != M_ON));
    checkOutput("frame_tick", int'(FrameTick), mTick);
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge Clk);
  endtask

  initial begin
    int n;
    int bad;
    int lit0;
    int lit2;

    applyStimulus(2);
    checkOutput("reset_sel", int'(Sel), 0);
    checkOutput("reset_dig_n", int'(Dig_n), 15);
    checkOutput("reset_blank", int'(Blank), 1);
    checkOutput("reset_tick", int'(FrameTick), 0);

    Rst_n = 1'b1;
    DigitMask = 4'b0111;
    applyStimulus(2);
    checkOutput("first_gap_blank", int'(Blank), 1);
    applyStimulus(1);
    checkOutput("first_on_d1", int'(Dig_n), 4'b1110);

    n = 0;
    while (!FrameTick && n < 100) begin applyStimulus(1); n++; end
    checkOutput("reach_first_tick", int'(n < 100), 1);
    n = 0;
    do begin applyStimulus(1); n++; end while (!FrameTick && n < 100);
    checkOutput("frame_len", n, 18);

    DigitMask = 4'b0101;
    applyStimulus(20);
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (Dig_n == 4'b1101 || Dig_n == 4'b0111) bad++;
      applyStimulus(1);
    end
    checkOutput("skip_masked_digits", bad, 0);

    DigitMask = 4'b0111;
    BlinkMask = 4'b0100;
    n = 0;
    while (!FrameTick && n < 100) begin applyStimulus(1); n++; end
    checkOutput("reach_blink_tick", int'(n < 100), 1);
    lit0 = 0;
    lit2 = 0;
    for (int c = 0; c < 72; c++) begin
      if (Dig_n == 4'b1011) lit2++;
      if (Dig_n == 4'b1110) lit0++;
      applyStimulus(1);
    end
    checkOutput("blink_d3_lit_cycles", lit2, 8);
    checkOutput("blink_d1_lit_cycles", lit0, 16);

    BlinkMask = 4'b0000;
    n = 0;
    while (!(Sel == 2'd1 && !Blank) && n < 100) begin applyStimulus(1); n++; end
    checkOutput("reach_sel1_on", int'(n < 100), 1);
    Manual = 1'b1;
    applyStimulus(20);
    checkOutput("manual_hold", int'(Dig_n), 4'b1101);
    Step = 1'b1;
    applyStimulus(2);
    checkOutput("step_not_yet", int'(Blank), 0);
    applyStimulus(1);
    checkOutput("step_gap", int'(Blank), 1);
    applyStimulus(2);
    Step = 1'b0;
    checkOutput("step_next_sel", int'(Sel), 2);
    checkOutput("step_next_dig", int'(Dig_n), 4'b1011);
    applyStimulus(10);
    Manual = 1'b0;

    n = 0;
    while (Blank && n < 100) begin applyStimulus(1); n++; end
    checkOutput("reach_on_mask", int'(n < 100), 1);
    DigitMask = 4'b0000;
    applyStimulus(1);
    checkOutput("mask_clear_dig", int'(Dig_n), 15);
    checkOutput("mask_clear_blank", int'(Blank), 1);
    applyStimulus(3);
    DigitMask = 4'b0010;
    applyStimulus(3);
    checkOutput("restore_sel", int'(Sel), 1);
    checkOutput("restore_dig", int'(Dig_n), 4'b1101);
    n = 0;
    while (!FrameTick && n < 20) begin applyStimulus(1); n++; end
    checkOutput("single_digit_tick", int'(n < 20), 1);

    DigitMask = 4'b0111;
    n = 0;
    while (!(Sel == 2'd2 && !Blank) && n < 100) begin applyStimulus(1); n++; end
    checkOutput("reach_on_reset", int'(n < 100), 1);
    Rst_n = 1'b0;
    applyStimulus(1);
    checkOutput("midreset_sel", int'(Sel), 0);
    checkOutput("midreset_dig", int'(Dig_n), 15);
    checkOutput("midreset_blank", int'(Blank), 1);
    checkOutput("midreset_tick", int'(FrameTick), 0);
    Rst_n = 1'b1;
    applyStimulus(3);
    checkOutput("restart_d1", int'(Dig_n), 4'b1110);

    for (int c = 0; c < 3000; c++) begin
      applyStimulus(1);
      if ($urandom_range(39) == 0) DigitMask = 4'($urandom_range(15));
      if ($urandom_range(59) == 0) BlinkMask = 4'($urandom_range(15));
      if ($urandom_range(79) == 0) Manual = ~Manual;
      if ($urandom_range(5) == 0) Step = ~Step;
      Rst_n = ($urandom_range(499) != 0);
    end
    Rst_n = 1'b1;
    applyStimulus(2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Sequencer for the irrigation panel's 4-digit multiplexed seven-segment display.
- Replaces the button-clocked digit selector with a clocked, time-multiplexed scan.
- Drives the digit-select code consumed by the segment mux and the active-low digit enables.
- Adds inter-digit blanking (anti-ghosting), per-digit skip masking, alert blinking and a manual step mode for the panel button.

Parameters:
- DWELL_CYC, 12500, clock cycles a digit is lit per slot (>=1).
- BLANK_CYC, 250, clock cycles all digits are dark between slots (>=1).
- BLINK_FRAMES, 250, completed frames per blink-phase toggle (>=1).

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  synchronous reset, active-low
- DigitMask  in  4  bit i = 1 enables digit i in the scan (digit 3 is normally tied 0)
- BlinkMask  in  4  bit i = 1 makes digit i blink (e.g. tank-empty alert)
- Manual  in  1  1 = advance only on Step, 0 = automatic dwell timing
- Step  in  1  asynchronous panel button, active-high
- Sel  out  2  index of the digit currently routed through the segment mux
- Dig_n  out  4  digit enables, active-low; bit 0 = D1 … bit 3 = D4
- Blank  out  1  1 while all digits are dark (GAP or IDLE); the segment mux forces segments off
- FrameTick  out  1  one-cycle pulse when the scan wraps

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values (Rst_n=0 at a clock edge): state=IDLE, Sel=0, Dig_n=4'b1111, Blank=1, FrameTick=0, blink phase=0, frame count=0, timer=0, synchroniser cleared. Reset mid-slot takes effect on that edge.
- States: IDLE, GAP, ON. All outputs are registered.
- IDLE:
  - Dig_n=1111, Blank=1.
  - If DigitMask != 0: Sel := lowest set index, go to GAP, timer=0.
- GAP:
  - Dig_n=1111, Blank=1.
  - Lasts exactly BLANK_CYC cycles, then ON, timer=0.
- ON:
  - Blank=0. Dig_n[Sel]=0, others 1.
  - Exception: if BlinkMask[Sel]=1 and blink phase=1, Dig_n stays 1111 with slot timing unchanged.
  - Manual=0: after exactly DWELL_CYC cycles, go to GAP.
  - Manual=1: the timer is held at 0; leave ON only on a synchronised Step rising edge.
- Advance, on the ON→GAP edge:
  - Sel := next index after Sel, searching upward modulo 4, with DigitMask bit set. DigitMask is sampled on this edge.
  - If only Sel is set, Sel is unchanged.
  - Sel changes only while Blank=1, never while a digit is lit.
- FrameTick is 1 for the cycle after an advance where new Sel <= old Sel (this includes the single-digit case).
- Blink:
  - The frame counter increments on each FrameTick.
  - At BLINK_FRAMES-1 plus a tick, the counter clears and the phase toggles.
- Mask cleared: DigitMask == 0 in any state → IDLE on the next edge. Dig_n=1111, Blank=1, Sel holds its value.
- Mask change during ON: the current slot completes if its bit is still set. If the current digit's bit is cleared, the slot ends on the next edge: go to GAP and advance.
- Step input:
  - Path is 2-FF synchroniser plus edge detect; an edge acts 3 clocks after the raw rise.
  - Step edges in GAP/IDLE, or with Manual=0, are discarded, not queued.
- Manual switching:
  - 0→1 during ON freezes the slot.
  - 1→0 restarts a full DWELL_CYC dwell.
  - A change during GAP does not affect the GAP length.
- Timer width: $clog2 of max(DWELL_CYC, BLANK_CYC)+1. Terminal-count compare only, no wrap.

Decomposition:
- Shared package: state enum (IDLE, GAP, ON), constant DIG_OFF = 4'b1111, next-enabled-index function over a 4-bit mask.
- One sub-module, step_sync: 2-FF synchroniser with rising-edge pulse output, reused for other panel buttons.

Test Plan (DWELL_CYC=4, BLANK_CYC=2, BLINK_FRAMES=2):
1. Reset, then DigitMask=0111, Manual=0 → IDLE, then GAP 2 cycles. Sel sequence 0,1,2,0… Each ON lasts 4 cycles with Dig_n=1110/1101/1011. FrameTick pulses once per 18-cycle frame.
2. DigitMask=0101 → Sel alternates 0,2. Dig_n never 1101 or 0111. Sel changes only while Blank=1.
3. BlinkMask=0100, DigitMask=0111 → digit 2 lit in frames 0–1, dark in frames 2–3, and so on. Slot timing is identical in both phases.
4. Manual=1 during ON at Sel=1 → Dig_n holds 1101 indefinitely. Step raised for 5 cycles → GAP starts 3 clocks after the rise, then Sel=2. Step asserted during GAP → ignored.
5. DigitMask 0111→0000 mid-ON → next edge Dig_n=1111, Blank=1, state IDLE. Restoring 0010 → GAP 2 cycles, then Sel=1 lit; FrameTick on each advance.
6. Rst_n=0 for one edge mid-ON → Dig_n=1111, Sel=0, Blank=1, FrameTick=0, blink phase=0. The scan restarts from the lowest enabled digit.
